// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// Each access runs IDLE -> GRANT (memory pins driven) -> RESP (one-cycle ack).
module mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         we,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DATA_W-1:0]          rdata,
  output logic [2:0]                 grant_id,
  output logic                       busy,
  output logic                       mem_operation,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_data_in,
  input  logic [DATA_W-1:0]          mem_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [2:0] LAST_INIT = 3'(NUM_REQ - 1);

  state_t            state_q, state_d;
  logic [2:0]        grant_id_q, grant_id_d;
  logic [2:0]        last_q, last_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              any_req;
  logic [2:0]        winner;
  int                idx;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Search last+1, last+2, ... (wrapping) and keep the first pending requester.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = 3'(idx);
      end
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        sel_we    = we[i];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_d        = last_q;
    rdata_d       = rdata_q;
    ack           = '0;
    mem_operation = 1'b0;
    mem_address   = '0;
    mem_data_in   = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_id_d = winner;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        mem_operation = sel_we;
        mem_address   = sel_addr;
        mem_data_in   = sel_wdata;
        // Memory read is combinational, so capture it on the GRANT-ending edge.
        if (!sel_we) begin
          rdata_d = mem_data_out;
        end
        state_d = RESP;
      end
      RESP: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          ack[i] = (grant_id_q == 3'(i));
        end
        last_d  = grant_id_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
      last_q     <= LAST_INIT;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      rdata_q    <= rdata_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rdata    = rdata_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin/shadow-memory reference model.
module tb_mem_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req, we;
  logic [N*8-1:0] addr, wdata;
  logic [N-1:0]   ack;
  logic [7:0]     rdata;
  logic [2:0]     grant_id;
  logic           busy;
  logic           mem_operation;
  logic [7:0]     mem_address, mem_data_in, mem_data_out;

  logic [7:0]     mem [256];
  logic [7:0]     ref_mem [256];
  logic           pre_we;
  logic [7:0]     pre_addr, pre_data;

  int errors = 0;
  int checks = 0;
  int ref_last;

  mem_arbiter #(.NUM_REQ(N), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .grant_id(grant_id), .busy(busy),
    .mem_operation(mem_operation), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural 256x8 memory: synchronous write, combinational read, bench preload port.
  always @(posedge clk) begin
    if (mem_operation) mem[mem_address] <= mem_data_in;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign mem_data_out = mem[mem_address];

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (last + k) % N;
      if (m[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we     = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    reset_n  = 1'b1;
    ref_last = N - 1;
    @(negedge clk);
  endtask

  task automatic run_access(input int who, input logic w, input logic [7:0] a, input logic [7:0] d,
                            output int lat, output logic [N-1:0] ackv, output logic [7:0] rd,
                            output int opcycles, output logic [7:0] opaddr, output logic [7:0] opdata);
    @(negedge clk);
    req = '0;
    req[who] = 1'b1;
    we[who] = w;
    addr[who*8 +: 8] = a;
    wdata[who*8 +: 8] = d;
    lat = -1; ackv = '0; rd = '0; opcycles = 0; opaddr = '0; opdata = '0;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(negedge clk);
      if (mem_operation) begin
        opcycles++;
        opaddr = mem_address;
        opdata = mem_data_in;
      end
      if (ack != '0) begin
        lat  = k;
        ackv = ack;
        rd   = rdata;
        req  = '0;
      end
    end
    req = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL reset_ack: got %b expected %b", ack, 4'b0000); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected %h", rdata, 8'h00); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("[TB] FAIL reset_grant_id: got %0d expected 0", grant_id); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (mem_operation !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_op: got %b expected 0", mem_operation); end
    checks++; if (mem_address !== 8'h00) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 00", mem_address); end
    reset_n  = 1'b1;
    ref_last = N - 1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int lat, opc;
    logic [N-1:0] av;
    logic [7:0] rd, oa, od;
    preload(8'h02, 8'h68);
    run_access(0, 1'b0, 8'h02, 8'h00, lat, av, rd, opc, oa, od);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL read_latency: got %0d expected 2", lat); end
    checks++; if (av !== 4'b0001) begin errors++; $display("[TB] FAIL read_ack: got %b expected 0001", av); end
    checks++; if (rd !== 8'h68) begin errors++; $display("[TB] FAIL read_rdata: got %h expected 68", rd); end
    checks++; if (opc !== 0) begin errors++; $display("[TB] FAIL read_mem_op_cycles: got %0d expected 0", opc); end
  endtask

  task automatic test_write_readback();
    int lat, opc;
    logic [N-1:0] av;
    logic [7:0] rd, oa, od;
    run_access(2, 1'b1, 8'h10, 8'hA5, lat, av, rd, opc, oa, od);
    checks++; if (opc !== 1) begin errors++; $display("[TB] FAIL write_op_cycles: got %0d expected 1", opc); end
    checks++; if (oa !== 8'h10) begin errors++; $display("[TB] FAIL write_mem_addr: got %h expected 10", oa); end
    checks++; if (od !== 8'hA5) begin errors++; $display("[TB] FAIL write_mem_data: got %h expected a5", od); end
    checks++; if (av !== 4'b0100) begin errors++; $display("[TB] FAIL write_ack: got %b expected 0100", av); end
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL write_latency: got %0d expected 2", lat); end
    run_access(1, 1'b0, 8'h10, 8'h00, lat, av, rd, opc, oa, od);
    checks++; if (rd !== 8'hA5) begin errors++; $display("[TB] FAIL readback_rdata: got %h expected a5", rd); end
    checks++; if (av !== 4'b0010) begin errors++; $display("[TB] FAIL readback_ack: got %b expected 0010", av); end
  endtask

  task automatic test_all_requesters();
    int n, prev, exp_idx;
    logic [N-1:0] exp_ack;
    do_reset();
    req = 4'b1111;
    we = '0;
    for (int i = 0; i < N; i++) addr[i*8 +: 8] = 8'h40 + 8'(i);
    n = 0;
    prev = -1;
    for (int t = 1; t <= 20 && n < 5; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        exp_idx = rr_pick(4'b1111, ref_last);
        exp_ack = 4'b0001 << exp_idx;
        checks++; if ($countones(ack) != 1) begin errors++; $display("[TB] FAIL all_onehot: got %b expected one bit", ack); end
        checks++; if (ack !== exp_ack) begin errors++; $display("[TB] FAIL all_order: got %b expected %b", ack, exp_ack); end
        checks++;
        if ((n == 0 && t != 2) || (n > 0 && t - prev != 3)) begin
          errors++; $display("[TB] FAIL all_spacing: got cycle %0d after %0d expected 3-cycle spacing", t, prev);
        end
        ref_last = exp_idx;
        prev = t;
        n++;
        if (n == 5) req = '0;
      end
    end
    req = '0;
    checks++; if (n != 5) begin errors++; $display("[TB] FAIL all_count: got %0d acks expected 5", n); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fairness();
    int lat, opc, n, idx;
    int got[3];
    int exp_seq[3];
    logic [N-1:0] av;
    logic [7:0] rd, oa, od;
    exp_seq[0] = 3; exp_seq[1] = 1; exp_seq[2] = 3;
    do_reset();
    run_access(2, 1'b0, 8'h40, 8'h00, lat, av, rd, opc, oa, od);
    @(negedge clk);
    req[3] = 1'b1; we[3] = 1'b0; addr[3*8 +: 8] = 8'h41;
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[1*8 +: 8] = 8'h42;
    n = 0;
    for (int t = 0; t < 20 && n < 3; t++) begin
      @(negedge clk);
      if (ack != '0) begin
        idx = -1;
        for (int b = 0; b < N; b++) if (ack[b]) idx = b;
        got[n] = idx;
        n++;
      end
    end
    req = '0;
    checks++; if (n != 3) begin errors++; $display("[TB] FAIL fair_count: got %0d acks expected 3", n); end
    for (int i = 0; i < n; i++) begin
      checks++; if (got[i] != exp_seq[i]) begin errors++; $display("[TB] FAIL fair_order[%0d]: got %0d expected %0d", i, got[i], exp_seq[i]); end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    preload(8'h05, 8'h28);
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b1; addr[7:0] = 8'h05; wdata[7:0] = 8'hFF;
    @(negedge clk);
    checks++; if (mem_operation !== 1'b1) begin errors++; $display("[TB] FAIL midrst_grant_op: got %b expected 1", mem_operation); end
    reset_n = 1'b0;
    #1;
    checks++; if (mem_operation !== 1'b0) begin errors++; $display("[TB] FAIL midrst_op_drop: got %b expected 0", mem_operation); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_ack: got %b expected 0000", ack); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 3'd0) begin errors++; $display("[TB] FAIL midrst_grant_id: got %0d expected 0", grant_id); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("[TB] FAIL midrst_rdata: got %h expected 00", rdata); end
    checks++; if (mem_data_in !== 8'h00) begin errors++; $display("[TB] FAIL midrst_mem_data_in: got %h expected 00", mem_data_in); end
    checks++; if (mem[5] !== 8'h28) begin errors++; $display("[TB] FAIL midrst_mem5: got %h expected 28", mem[5]); end
    req = '0; we = '0;
    reset_n = 1'b1;
    ref_last = N - 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL midrst_post_ack: got %b expected 0000", ack); end
    end
    checks++; if (mem[5] !== 8'h28) begin errors++; $display("[TB] FAIL midrst_post_mem5: got %h expected 28", mem[5]); end
  endtask

  task automatic test_idle();
    req = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
      checks++; if (mem_operation !== 1'b0) begin errors++; $display("[TB] FAIL idle_mem_op: got %b expected 0", mem_operation); end
      checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL idle_ack: got %b expected 0000", ack); end
    end
  endtask

  task automatic test_random();
    logic         pend[N];
    logic         twe[N];
    logic [7:0]   ta[N], td[N];
    logic         newtx, g_we;
    logic [7:0]   g_a, g_d, exp_rd, last_rd;
    logic [N-1:0] m, exp_ack;
    int next_free, ack_t, grant_t, who, w;
    do_reset();
    for (int i = 0; i < 8; i++) preload(8'h40 + 8'(i), 8'($urandom));
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; twe[i] = 1'b0; ta[i] = 8'h40; td[i] = 8'h00;
    end
    last_rd = 8'h00; exp_rd = 8'h00;
    g_we = 1'b0; g_a = '0; g_d = '0;
    next_free = 0; ack_t = -1; grant_t = -1; who = 0;
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (t == ack_t) begin
        exp_ack = 4'b0001 << who;
        checks++; if (ack !== exp_ack) begin errors++; $display("[TB] FAIL rand_ack t=%0d: got %b expected %b", t, ack, exp_ack); end
        checks++; if (rdata !== exp_rd) begin errors++; $display("[TB] FAIL rand_rdata t=%0d: got %h expected %h", t, rdata, exp_rd); end
      end else begin
        checks++; if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL rand_noack t=%0d: got %b expected 0000", t, ack); end
      end
      if (t == grant_t) begin
        checks++; if (mem_operation !== g_we) begin errors++; $display("[TB] FAIL rand_op t=%0d: got %b expected %b", t, mem_operation, g_we); end
        checks++; if (mem_address !== g_a) begin errors++; $display("[TB] FAIL rand_addr t=%0d: got %h expected %h", t, mem_address, g_a); end
        if (g_we) begin
          checks++; if (mem_data_in !== g_d) begin errors++; $display("[TB] FAIL rand_wdata t=%0d: got %h expected %h", t, mem_data_in, g_d); end
        end
      end else begin
        checks++; if (mem_operation !== 1'b0) begin errors++; $display("[TB] FAIL rand_idle_op t=%0d: got %b expected 0", t, mem_operation); end
      end
      for (int i = 0; i < N; i++) begin
        newtx = 1'b0;
        if (t == ack_t && i == who) begin
          pend[i] = ($urandom_range(0, 1) == 1);
          newtx = pend[i];
        end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          newtx = 1'b1;
        end
        if (newtx) begin
          twe[i] = ($urandom_range(0, 1) == 1);
          ta[i]  = 8'h40 + 8'($urandom_range(0, 7));
          td[i]  = 8'($urandom);
        end
        req[i] = pend[i];
        we[i] = twe[i];
        addr[i*8 +: 8] = ta[i];
        wdata[i*8 +: 8] = td[i];
      end
      if (t >= next_free) begin
        for (int i = 0; i < N; i++) m[i] = pend[i];
        w = rr_pick(m, ref_last);
        if (w >= 0) begin
          who = w;
          grant_t = t + 1;
          ack_t = t + 2;
          g_we = twe[w]; g_a = ta[w]; g_d = td[w];
          if (g_we) ref_mem[g_a] = g_d;
          else last_rd = ref_mem[g_a];
          exp_rd = last_rd;
          ref_last = w;
          next_free = t + 3;
        end
      end
    end
    req = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_readback();
    test_all_requesters();
    test_fairness();
    test_reset_mid_write();
    test_idle();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
